// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC selection and a read-only
// instruction memory indexed combinationally by the current PC.

module ifu_im #(
  parameter int IM_WORDS = 1024,
  parameter int AW       = 10
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  // Contents are loaded externally (memory-load task or hierarchical writes); the design never writes them.
  logic [31:0] im [IM_WORDS] = '{default: 32'h0};

  assign data = im[addr];

endmodule

module ifu #(
  parameter int          IM_WORDS = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] register,
  output logic [31:0] inst
);

  localparam int AW = $clog2(IM_WORDS);

  localparam logic [1:0] IFU_SEL_NORM       = 2'b00;
  localparam logic [1:0] IFU_SEL_RELATIVE   = 2'b01;
  localparam logic [1:0] IFU_SEL_IRRELATIVE = 2'b10;
  localparam logic [1:0] IFU_SEL_REGISTER   = 2'b11;

  // The declaration value gives a defined PC before the first clock edge.
  logic [31:0] pc = RESET_PC;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;

  ifu_im #(
    .IM_WORDS (IM_WORDS),
    .AW       (AW)
  ) im (
    .addr (pc[AW+1:2]),
    .data (inst)
  );

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = {{14{inst[15]}}, inst[15:0], 2'b00};
    pc_d     = pc_plus4;
    case (npc_sel)
      IFU_SEL_NORM:       pc_d = pc_plus4;
      IFU_SEL_RELATIVE:   pc_d = pc_plus4 + br_off;
      IFU_SEL_IRRELATIVE: pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
      IFU_SEL_REGISTER:   pc_d = register;
      default:            pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu: a reference model predicts pc/inst after every
// edge, and a monitor compares the DUT against the queued predictions.

module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [1:0]  S_NORM = 2'b00;
  localparam logic [1:0]  S_REL  = 2'b01;
  localparam logic [1:0]  S_IRR  = 2'b10;
  localparam logic [1:0]  S_REG  = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] register = 32'h0;
  logic [31:0] inst;

  always #5 clk = ~clk;

  ifu #(
    .IM_WORDS (1024),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .npc_sel  (npc_sel),
    .register (register),
    .inst     (inst)
  );

  // ---------------- reference model ----------------
  logic [31:0] mem [1024];
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] sel,
                                           input logic [31:0] r, input logic rst);
    logic [31:0] word;
    int          off;
    word = mem[cur[11:2]];
    off  = int'($signed(word[15:0]));
    if (rst) return RESET_PC;
    case (sel)
      S_NORM:  return cur + 32'd4;
      S_REL:   return cur + 32'd4 + 32'(off * 4);
      S_IRR:   return ((cur + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
      default: return r;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic rst, input logic [1:0] sel,
                      input logic [31:0] r);
    @(negedge clk);
    reset    = rst;
    npc_sel  = sel;
    register = r;
    m_pc = ref_next(m_pc, sel, r, rst);
    exp_q.push_back({m_pc, mem[m_pc[11:2]]});
    tag_q.push_back(tag);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [63:0] e;
    string       t;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, " pc"}, dut.pc, e[63:32]);
      check({t, " inst"}, inst, e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sel;
    logic [31:0] r;
    logic        rst;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0][15:0] = 16'h0001;
    mem[2][15:0] = 16'hFFFE;
    mem[3]       = 32'h0800_1234;

    #1;
    for (int i = 0; i < 1024; i++) dut.im.im[i] = mem[i];
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("powerup pc", dut.pc, RESET_PC);
    check("powerup inst", inst, mem[0]);

    step("rst_over_reg", 1'b1, S_REG, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) step("norm_seq", 1'b0, S_NORM, 32'h0);

    step("rst", 1'b1, S_NORM, 32'h0);
    step("rel_fwd", 1'b0, S_REL, 32'h0);
    step("rel_back", 1'b0, S_REL, 32'h0);
    step("norm", 1'b0, S_NORM, 32'h0);
    step("norm", 1'b0, S_NORM, 32'h0);
    step("irr", 1'b0, S_IRR, 32'h0);
    step("reg", 1'b0, S_REG, 32'h0000_3008);
    step("norm", 1'b0, S_NORM, 32'h0);
    step("norm", 1'b0, S_NORM, 32'h0);
    step("reg_top", 1'b0, S_REG, 32'hFFFF_FFFC);
    step("wrap", 1'b0, S_NORM, 32'h0);
    step("reg_unaligned", 1'b0, S_REG, 32'h1234_5677);
    step("norm", 1'b0, S_NORM, 32'h0);
    step("rst_over_rel", 1'b1, S_REL, 32'h0);
    step("after_rst", 1'b0, S_NORM, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) r = $urandom;
      else r = 32'h0000_3000 | (32'($urandom_range(0, 1023)) << 2);
      step("random", rst, sel, r);
    end

    @(negedge clk);
    reset   = 1'b0;
    npc_sel = S_NORM;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
